// File: rtl/snake_dir_ctrl.sv
// Snake heading controller: run/pause/over FSM, turn-request queue, registered step strobe.
// Optional SNAKE_TURN_COUNT_EN adds a saturating turn_count output.
module snake_dir_ctrl #(
  parameter int         QDEPTH    = 2,
  parameter logic [1:0] START_DIR = 2'b01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_center,
  input  logic       move_tick,
  input  logic       collision,
  output logic [1:0] dir,
  output logic       step,
  output logic       running,
  output logic       paused,
  output logic       game_over,
  output logic [2:0] q_count
`ifdef SNAKE_TURN_COUNT_EN
  ,
  output logic [15:0] turn_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_e;

  // Handshake: inputs are single-cycle pulses with no back-pressure; a pulse
  // that cannot be used in the cycle it arrives is dropped.
  state_e     state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic [1:0] fifo_q [QDEPTH];
  logic [1:0] fifo_d [QDEPTH];
  logic [2:0] q_count_q, q_count_d;
  logic       step_q, step_d;
  logic [1:0] tail, req;
  logic       req_v, accept, pop;

  // Acceptance is always judged against the pre-pop tail of the queue.
  always_comb begin
    tail = dir_q;
    for (int i = 0; i < QDEPTH; i++) begin
      if (3'(i) + 3'd1 == q_count_q) tail = fifo_q[i];
    end
    req_v = 1'b1;
    req   = 2'b00;
    if (btn_up)         req = 2'b00;
    else if (btn_right) req = 2'b01;
    else if (btn_down)  req = 2'b10;
    else if (btn_left)  req = 2'b11;
    else                req_v = 1'b0;
    accept = req_v && (req != tail) && (req != (tail ^ 2'b10)) &&
             (q_count_q < 3'(QDEPTH));
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    fifo_d    = fifo_q;
    q_count_d = q_count_q;
    step_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: if (btn_center) state_d = RUN;
      RUN: begin
        if (collision) begin
          state_d   = OVER;
          q_count_d = 3'd0;
        end else if (btn_center) begin
          state_d   = PAUSE;
          q_count_d = 3'd0;
        end else begin
          if (move_tick) begin
            step_d = 1'b1;
            if (q_count_q != 3'd0) begin
              pop   = 1'b1;
              dir_d = fifo_q[0];
              for (int i = 0; i < QDEPTH - 1; i++) fifo_d[i] = fifo_q[i+1];
            end
          end
          if (accept) begin
            for (int i = 0; i < QDEPTH; i++) begin
              if (3'(i) == q_count_q - {2'b00, pop}) fifo_d[i] = req;
            end
          end
          q_count_d = q_count_q + {2'b00, accept} - {2'b00, pop};
        end
      end
      PAUSE: if (btn_center) state_d = RUN;
      OVER: begin
        if (btn_center) begin
          state_d   = IDLE;
          dir_d     = START_DIR;
          q_count_d = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dir_q     <= START_DIR;
      q_count_q <= 3'd0;
      step_q    <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) fifo_q[i] <= 2'b00;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      q_count_q <= q_count_d;
      step_q    <= step_d;
      fifo_q    <= fifo_d;
    end
  end

`ifdef SNAKE_TURN_COUNT_EN
  logic [15:0] turn_count_q, turn_count_d;

  always_comb begin
    turn_count_d = turn_count_q;
    if (state_q == OVER && btn_center)
      turn_count_d = 16'd0;
    else if (pop && fifo_q[0] != dir_q && turn_count_q != 16'hFFFF)
      turn_count_d = turn_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) turn_count_q <= 16'd0;
    else       turn_count_q <= turn_count_d;
  end

  assign turn_count = turn_count_q;
`endif

  assign dir       = dir_q;
  assign step      = step_q;
  assign q_count   = q_count_q;
  assign running   = (state_q == RUN);
  assign paused    = (state_q == PAUSE);
  assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios plus random traffic against a
// queue-based model of the game rules.
module tb_snake_dir_ctrl;
  localparam int         QDEPTH    = 2;
  localparam logic [1:0] START_DIR = 2'b01;
  localparam logic [4:0] B_UP = 5'b00001, B_RIGHT = 5'b00010, B_DOWN = 5'b00100,
                         B_LEFT = 5'b01000, B_CTR = 5'b10000, B_NONE = 5'b00000;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_OVER = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_center = 0;
  logic move_tick = 0, collision = 0;
  logic [1:0] dir;
  logic step, running, paused, game_over;
  logic [2:0] q_count;
`ifdef SNAKE_TURN_COUNT_EN
  logic [15:0] turn_count;
`endif

  int checks = 0;
  int fails  = 0;

  // model
  int         m_state;
  logic [1:0] m_dir;
  logic [1:0] mq[$];
  logic       m_step;
  int         m_tc;

  always #5 clk = ~clk;

  snake_dir_ctrl #(.QDEPTH(QDEPTH), .START_DIR(START_DIR)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_center(btn_center),
    .move_tick(move_tick), .collision(collision),
    .dir(dir), .step(step), .running(running), .paused(paused),
    .game_over(game_over), .q_count(q_count)
`ifdef SNAKE_TURN_COUNT_EN
    , .turn_count(turn_count)
`endif
  );

  task automatic model_reset();
    m_state = S_IDLE; m_dir = START_DIR; mq.delete(); m_step = 0; m_tc = 0;
  endtask

  task automatic model_step(input logic [4:0] b, input logic tick, input logic coll);
    logic [1:0] tail, r, nd;
    logic have;
    m_step = 0;
    case (m_state)
      S_IDLE: if (b[4]) m_state = S_RUN;
      S_RUN: begin
        if (coll) begin
          m_state = S_OVER; mq.delete();
        end else if (b[4]) begin
          m_state = S_PAUSE; mq.delete();
        end else begin
          tail = (mq.size() > 0) ? mq[mq.size()-1] : m_dir;
          have = 1;
          if (b[0]) r = 2'd0;
          else if (b[1]) r = 2'd1;
          else if (b[2]) r = 2'd2;
          else if (b[3]) r = 2'd3;
          else begin have = 0; r = 2'd0; end
          have = have && (r != tail) && (r != (tail ^ 2'b10)) && (mq.size() < QDEPTH);
          if (tick) begin
            m_step = 1;
            if (mq.size() > 0) begin
              nd = mq.pop_front();
              if (nd != m_dir && m_tc < 65535) m_tc++;
              m_dir = nd;
            end
          end
          if (have) mq.push_back(r);
        end
      end
      S_PAUSE: if (b[4]) m_state = S_RUN;
      default: if (b[4]) begin
        m_state = S_IDLE; m_dir = START_DIR; mq.delete(); m_tc = 0;
      end
    endcase
  endtask

  // One clock: drive at negedge, update model, settle past the posedge.
  task automatic cyc(input logic rst, input logic [4:0] b, input logic tick, input logic coll);
    @(negedge clk);
    reset = rst;
    btn_up = b[0]; btn_right = b[1]; btn_down = b[2]; btn_left = b[3]; btn_center = b[4];
    move_tick = tick; collision = coll;
    if (rst) model_reset();
    else     model_step(b, tick, coll);
    @(posedge clk);
    #1;
    reset = 0;
    {btn_up, btn_right, btn_down, btn_left, btn_center, move_tick, collision} = '0;
  endtask

  task automatic test_reset();
    cyc(1, B_NONE, 0, 0);
    checks++; if (dir !== 2'b01) begin fails++; $display("FAIL reset_dir got %0d exp 1", dir); end
    checks++; if ({step, running, paused, game_over} !== 4'b0000) begin
      fails++; $display("FAIL reset_status got %b exp 0000", {step, running, paused, game_over}); end
    checks++; if (q_count !== 3'd0) begin fails++; $display("FAIL reset_qcount got %0d exp 0", q_count); end
`ifdef SNAKE_TURN_COUNT_EN
    checks++; if (turn_count !== 16'd0) begin fails++; $display("FAIL reset_turn_count got %0d exp 0", turn_count); end
`endif
    // IDLE ignores direction buttons and ticks
    cyc(0, B_UP, 1, 0);
    checks++; if ({running, step, q_count} !== 5'b0) begin
      fails++; $display("FAIL idle_ignore got run=%b step=%b q=%0d exp 0", running, step, q_count); end
  endtask

  task automatic test_start_turn();
    cyc(1, B_NONE, 0, 0);
    cyc(0, B_CTR, 0, 0);
    checks++; if (running !== 1'b1 || dir !== 2'b01) begin
      fails++; $display("FAIL start got run=%b dir=%0d exp run=1 dir=1", running, dir); end
    cyc(0, B_UP, 0, 0);
    checks++; if (q_count !== 3'd1) begin fails++; $display("FAIL enqueue_up got %0d exp 1", q_count); end
    cyc(0, B_NONE, 1, 0);
    checks++; if (step !== 1'b1 || dir !== 2'b00 || q_count !== 3'd0) begin
      fails++; $display("FAIL tick_pop got step=%b dir=%0d q=%0d exp 1/0/0", step, dir, q_count); end
    cyc(0, B_NONE, 0, 0);
    checks++; if (step !== 1'b0) begin fails++; $display("FAIL step_one_cycle got %b exp 0", step); end
  endtask

  task automatic test_reverse();
    cyc(1, B_NONE, 0, 0); cyc(0, B_CTR, 0, 0);
    cyc(0, B_LEFT, 0, 0);
    checks++; if (q_count !== 3'd0) begin fails++; $display("FAIL reverse_drop got %0d exp 0", q_count); end
    cyc(0, B_RIGHT, 0, 0);
    checks++; if (q_count !== 3'd0) begin fails++; $display("FAIL same_drop got %0d exp 0", q_count); end
    cyc(0, B_UP, 0, 0); cyc(0, B_LEFT, 0, 0);
    cyc(0, B_NONE, 1, 0);
    checks++; if (dir !== 2'b00) begin fails++; $display("FAIL combo_first got %0d exp 0", dir); end
    cyc(0, B_NONE, 1, 0);
    checks++; if (dir !== 2'b11 || q_count !== 3'd0) begin
      fails++; $display("FAIL combo_second got dir=%0d q=%0d exp 3/0", dir, q_count); end
  endtask

  task automatic test_depth();
    cyc(1, B_NONE, 0, 0); cyc(0, B_CTR, 0, 0);
    cyc(0, B_UP, 0, 0); cyc(0, B_LEFT, 0, 0); cyc(0, B_DOWN, 0, 0);
    checks++; if (q_count !== 3'd2) begin fails++; $display("FAIL depth_full got %0d exp 2", q_count); end
    cyc(0, B_NONE, 1, 0);
    checks++; if (dir !== 2'b00 || q_count !== 3'd1) begin
      fails++; $display("FAIL depth_pop1 got dir=%0d q=%0d exp 0/1", dir, q_count); end
    cyc(0, B_NONE, 1, 0);
    checks++; if (dir !== 2'b11 || q_count !== 3'd0) begin
      fails++; $display("FAIL depth_pop2 got dir=%0d q=%0d exp 3/0", dir, q_count); end
    // empty-queue tick: request is queued, dir holds
    cyc(0, B_UP, 1, 0);
    checks++; if (dir !== 2'b11 || q_count !== 3'd1 || step !== 1'b1) begin
      fails++; $display("FAIL tick_push_empty got dir=%0d q=%0d step=%b exp 3/1/1", dir, q_count, step); end
  endtask

  task automatic test_simultaneous();
    cyc(1, B_NONE, 0, 0); cyc(0, B_CTR, 0, 0);
    cyc(0, B_UP | B_DOWN, 0, 0);
    checks++; if (q_count !== 3'd1) begin fails++; $display("FAIL priority_qcount got %0d exp 1", q_count); end
    cyc(0, B_NONE, 1, 0);
    checks++; if (dir !== 2'b00) begin fails++; $display("FAIL priority_dir got %0d exp 0", dir); end
  endtask

  task automatic test_collision();
    cyc(1, B_NONE, 0, 0); cyc(0, B_CTR, 0, 0);
    cyc(0, B_UP, 0, 0); cyc(0, B_NONE, 1, 0); cyc(0, B_LEFT, 0, 0);
    cyc(0, B_CTR, 1, 1);
    checks++; if ({game_over, paused, running, step} !== 4'b1000) begin
      fails++; $display("FAIL collide_win got go/pa/ru/st=%b exp 1000", {game_over, paused, running, step}); end
    checks++; if (dir !== 2'b00 || q_count !== 3'd0) begin
      fails++; $display("FAIL collide_flush got dir=%0d q=%0d exp 0/0", dir, q_count); end
    cyc(0, B_CTR, 0, 0);
    checks++; if (game_over !== 1'b0 || running !== 1'b0 || dir !== 2'b01 || q_count !== 3'd0) begin
      fails++; $display("FAIL restart got go=%b run=%b dir=%0d q=%0d exp 0/0/1/0", game_over, running, dir, q_count); end
  endtask

  task automatic test_pause();
    cyc(1, B_NONE, 0, 0); cyc(0, B_CTR, 0, 0); cyc(0, B_UP, 0, 0);
    cyc(0, B_CTR, 0, 0);
    checks++; if (paused !== 1'b1 || q_count !== 3'd0) begin
      fails++; $display("FAIL pause_entry got pa=%b q=%0d exp 1/0", paused, q_count); end
    for (int i = 0; i < 3; i++) begin
      cyc(0, B_LEFT, 1, 1);
      checks++; if (step !== 1'b0 || paused !== 1'b1) begin
        fails++; $display("FAIL pause_tick got step=%b pa=%b exp 0/1", step, paused); end
    end
    cyc(0, B_CTR, 0, 0);
    checks++; if (running !== 1'b1 || q_count !== 3'd0) begin
      fails++; $display("FAIL resume got run=%b q=%0d exp 1/0", running, q_count); end
    cyc(0, B_NONE, 1, 0);
    checks++; if (dir !== 2'b01 || step !== 1'b1) begin
      fails++; $display("FAIL resume_tick got dir=%0d step=%b exp 1/1", dir, step); end
  endtask

  task automatic test_random();
    logic [4:0] b;
    logic tick, coll, rst;
    cyc(1, B_NONE, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      b = B_NONE;
      for (int k = 0; k < 4; k++) b[k] = ($urandom_range(0, 5) == 0);
      b[4] = ($urandom_range(0, 30) == 0);
      tick = ($urandom_range(0, 3) == 0);
      coll = ($urandom_range(0, 80) == 0);
      rst  = ($urandom_range(0, 700) == 0);
      cyc(rst, b, tick, coll);
      checks++;
      if (dir !== m_dir || step !== m_step || q_count !== 3'(mq.size()) ||
          running !== (m_state == S_RUN) || paused !== (m_state == S_PAUSE) ||
          game_over !== (m_state == S_OVER)
`ifdef SNAKE_TURN_COUNT_EN
          || turn_count !== 16'(m_tc)
`endif
          ) begin
        fails++;
        $display("FAIL random cyc %0d got dir=%0d step=%b q=%0d st=%b exp dir=%0d step=%b q=%0d state=%0d",
                 n, dir, step, q_count, {running, paused, game_over}, m_dir, m_step, mq.size(), m_state);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start_turn();
    test_reverse();
    test_depth();
    test_simultaneous();
    test_collision();
    test_pause();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
